// File: rtl/bcd_stopwatch_src_if.sv
// Button inputs and display-side outputs of the BCD stopwatch source.
// master: the stopwatch itself; slave: the downstream scan driver plus button wiring.
interface bcd_stopwatch_src_if;
    logic        btn_ss;
    logic        btn_clr;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        running;
    logic        upd;
    logic        ovf;

    modport master (
        input  btn_ss, btn_clr,
        output bcd, blank, running, upd, ovf
    );

    modport slave (
        output btn_ss, btn_clr,
        input  bcd, blank, running, upd, ovf
    );
endinterface

// File: rtl/bcd_stopwatch_src.sv
// 4-digit BCD stopwatch: debounced start/stop and clear buttons, run/pause/clear FSM,
// prescaled BCD count with leading-zero blanking and update/overflow strobes.
module bcd_stopwatch_src #(
    parameter int unsigned TICK_DIV   = 625,
    parameter int unsigned DEB_CYCLES = 16,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_stopwatch_src_if.master  bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StFull} state_e;

    // Index 0: start/stop, index 1: clear
    logic [1:0]         s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, press;
    logic [1:0][DW-1:0] cnt_q, cnt_d;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          running_q, running_d;
    logic          upd_q, upd_d;
    logic          ovf_q, ovf_d;
    logic          tick;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        s1_d  = {bus.btn_clr, bus.btn_ss};
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end
        end
        press = deb_d & ~deb_q;
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        bcd_d   = bcd_q;
        upd_d   = 1'b0;
        ovf_d   = 1'b0;
        tick    = (state_q == StRun) && (pre_q == PW'(TICK_DIV - 1));

        if (press[1]) begin
            state_d = StIdle;
            bcd_d   = '0;
            pre_d   = '0;
            upd_d   = (bcd_q != 16'h0000);
        end else begin
            if (state_q == StRun) begin
                pre_d = tick ? '0 : pre_q + PW'(1);
            end
            unique case (state_q)
                StIdle:  if (press[0]) state_d = StRun;
                StRun:   if (press[0]) state_d = StPause;
                StPause: if (press[0]) state_d = StRun;
                StFull:  state_d = StFull;
                default: state_d = StIdle;
            endcase
            if (tick) begin
                if (bcd_q == 16'h9999) begin
                    ovf_d = 1'b1;
                    if (WRAP) begin
                        bcd_d = '0;
                        upd_d = 1'b1;
                    end else begin
                        // Saturation wins over a same-cycle start/stop press
                        state_d = StFull;
                    end
                end else begin
                    bcd_d = bcd_inc(bcd_q);
                    upd_d = 1'b1;
                end
            end
        end
        running_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            state_q   <= StIdle;
            pre_q     <= '0;
            bcd_q     <= '0;
            running_q <= 1'b0;
            upd_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pre_q     <= pre_d;
            bcd_q     <= bcd_d;
            running_q <= running_d;
            upd_q     <= upd_d;
            ovf_q     <= ovf_d;
        end
    end

    logic b3, b2, b1;
    assign b3 = (bcd_q[15:12] == 4'd0);
    assign b2 = b3 & (bcd_q[11:8] == 4'd0);
    assign b1 = b2 & (bcd_q[7:4] == 4'd0);

    assign bus.bcd     = bcd_q;
    assign bus.blank   = {b3, b2, b1, 1'b0};
    assign bus.running = running_q;
    assign bus.upd     = upd_q;
    assign bus.ovf     = ovf_q;

endmodule
